// File: rtl/vend_pkg.sv
// Shared types and constants for the vending order sequencer.
// Contents: FSM state enum, default field widths, credit saturation limit.
package vend_pkg;

    localparam int unsigned CODE_W  = 2;
    localparam int unsigned COUNT_W = 3;
    localparam int unsigned MONEY_W = 4;

    // Largest credit value a coin may bring the register up to.
    localparam int unsigned CREDIT_MAX = (1 << MONEY_W) - 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CREDIT,
        ST_QUERY,
        ST_DISPENSE,
        ST_CHANGE
    } state_t;

endpackage

// File: rtl/vend_order_sequencer_if.sv
// Bus bundle between the order sequencer and its environment.
// Groups the coin mechanism, the selection panel, the pricer and the
// dispense/change outputs.
// Modports:
//   master - the sequencer (drives req_*, dispense, change, credit, busy)
//   slave  - the environment (drives coins, selection, cancel, pricer response)
interface vend_order_sequencer_if #(
    parameter int unsigned CODE_W  = vend_pkg::CODE_W,
    parameter int unsigned COUNT_W = vend_pkg::COUNT_W,
    parameter int unsigned MONEY_W = vend_pkg::MONEY_W
);
    logic               coin_valid;
    logic [MONEY_W-1:0] coin_value;
    logic               coin_reject;
    logic               sel_valid;
    logic [CODE_W-1:0]  sel_code;
    logic [COUNT_W-1:0] sel_count;
    logic               cancel;
    logic [CODE_W-1:0]  req_code;
    logic [COUNT_W-1:0] req_count;
    logic [MONEY_W-1:0] req_money;
    logic               rsp_possible;
    logic [MONEY_W-1:0] rsp_remaining;
    logic               dispense;
    logic [CODE_W-1:0]  dispense_code;
    logic               deny;
    logic               change_valid;
    logic [MONEY_W-1:0] change_amount;
    logic [MONEY_W-1:0] credit;
    logic               busy;

    modport master (
        input  coin_valid, coin_value, sel_valid, sel_code, sel_count, cancel,
               rsp_possible, rsp_remaining,
        output coin_reject, req_code, req_count, req_money, dispense,
               dispense_code, deny, change_valid, change_amount, credit, busy
    );

    modport slave (
        output coin_valid, coin_value, sel_valid, sel_code, sel_count, cancel,
               rsp_possible, rsp_remaining,
        input  coin_reject, req_code, req_count, req_money, dispense,
               dispense_code, deny, change_valid, change_amount, credit, busy
    );

endinterface

// File: rtl/vend_credit_acc.sv
// Credit accumulator: adds accepted coins, refuses coins that would overflow
// or that arrive while crediting is not allowed, and clears on request.
// Ports:
//   clk, rst_n          - clock, synchronous active-low reset
//   coin_valid/value    - coin strobe and value
//   coin_en             - coins may be credited this cycle
//   clear               - zero the credit (takes effect next cycle)
//   credit              - registered credit
//   coin_reject         - registered one-cycle pulse for a refused coin
module vend_credit_acc #(
    parameter int unsigned MONEY_W = vend_pkg::MONEY_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               coin_valid,
    input  logic [MONEY_W-1:0] coin_value,
    input  logic               coin_en,
    input  logic               clear,
    output logic [MONEY_W-1:0] credit,
    output logic               coin_reject
);

    logic [MONEY_W:0] sum_c;
    logic             ovf_c;

    // Carry out of the extended sum marks a coin that would wrap the credit.
    assign sum_c = (MONEY_W+1)'(credit) + (MONEY_W+1)'(coin_value);
    assign ovf_c = sum_c[MONEY_W];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            credit      <= '0;
            coin_reject <= 1'b0;
        end else begin
            coin_reject <= coin_valid & (~coin_en | ovf_c);
            if (clear) begin
                credit <= '0;
            end else if (coin_valid && coin_en && !ovf_c) begin
                credit <= sum_c[MONEY_W-1:0];
            end
        end
    end

endmodule

// File: rtl/vend_order_sequencer.sv
// Order sequencer in front of the combinational pricing core: collects
// credit, latches a selection, queries the pricer for one cycle, then
// dispenses items and returns change or a refund.
// Ports:
//   clk, rst_n - clock, synchronous active-low reset
//   bus        - vend_order_sequencer_if.master (coins, selection, cancel,
//                pricer request/response, dispense, deny, change, credit, busy)
// Build option: VEND_REFUND_TIMEOUT_EN adds an idle refund timer in CREDIT
// that fires after TIMEOUT_CYC quiet cycles.
module vend_order_sequencer #(
    parameter int unsigned CODE_W      = vend_pkg::CODE_W,
    parameter int unsigned COUNT_W     = vend_pkg::COUNT_W,
    parameter int unsigned MONEY_W     = vend_pkg::MONEY_W,
    parameter int unsigned TIMEOUT_CYC = 1000
) (
    input logic                    clk,
    input logic                    rst_n,
    vend_order_sequencer_if.master bus
);
    import vend_pkg::*;

    state_t             state_q, state_n;
    logic [CODE_W-1:0]  code_q, code_n;
    logic [COUNT_W-1:0] count_q, count_n;
    logic [COUNT_W-1:0] left_q, left_n;
    logic [MONEY_W-1:0] rem_q, rem_n;
    logic               dispense_q, dispense_n;
    logic [CODE_W-1:0]  dcode_q, dcode_n;
    logic               deny_q, deny_n;
    logic               chg_valid_q, chg_valid_n;
    logic [MONEY_W-1:0] chg_amount_q, chg_amount_n;
    logic               busy_q, busy_n;
    logic               coin_en_c, clear_c, timeout_c;
    logic [MONEY_W-1:0] credit;

    vend_credit_acc #(.MONEY_W(MONEY_W)) u_credit (
        .clk         (clk),
        .rst_n       (rst_n),
        .coin_valid  (bus.coin_valid),
        .coin_value  (bus.coin_value),
        .coin_en     (coin_en_c),
        .clear       (clear_c),
        .credit      (credit),
        .coin_reject (bus.coin_reject)
    );

`ifdef VEND_REFUND_TIMEOUT_EN
    // Counts quiet cycles spent in CREDIT; any strobe restarts it.
    localparam int unsigned IDLE_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [IDLE_W-1:0] idle_q;
    logic              activity_c;

    assign activity_c = bus.coin_valid | bus.sel_valid | bus.cancel;
    assign timeout_c  = (state_q == ST_CREDIT) && !activity_c &&
                        (idle_q == IDLE_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idle_q <= '0;
        end else if (state_q != ST_CREDIT || activity_c) begin
            idle_q <= '0;
        end else if (!timeout_c) begin
            idle_q <= idle_q + IDLE_W'(1);
        end
    end
`else
    assign timeout_c = 1'b0;
`endif

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            code_q       <= '0;
            count_q      <= '0;
            left_q       <= '0;
            rem_q        <= '0;
            dispense_q   <= 1'b0;
            dcode_q      <= '0;
            deny_q       <= 1'b0;
            chg_valid_q  <= 1'b0;
            chg_amount_q <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_n;
            code_q       <= code_n;
            count_q      <= count_n;
            left_q       <= left_n;
            rem_q        <= rem_n;
            dispense_q   <= dispense_n;
            dcode_q      <= dcode_n;
            deny_q       <= deny_n;
            chg_valid_q  <= chg_valid_n;
            chg_amount_q <= chg_amount_n;
            busy_q       <= busy_n;
        end
    end

    // Next state and next registered outputs; cancel beats selection beats coin.
    always_comb begin
        state_n      = state_q;
        code_n       = code_q;
        count_n      = count_q;
        left_n       = left_q;
        rem_n        = rem_q;
        dispense_n   = 1'b0;
        dcode_n      = '0;
        deny_n       = 1'b0;
        chg_valid_n  = 1'b0;
        chg_amount_n = '0;
        coin_en_c    = 1'b0;
        clear_c      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                coin_en_c = 1'b1;
                if (bus.coin_valid) begin
                    state_n = ST_CREDIT;
                end
            end
            ST_CREDIT: begin
                if (bus.cancel || timeout_c) begin
                    chg_valid_n  = (credit != '0);
                    chg_amount_n = credit;
                    state_n      = ST_CHANGE;
                end else if (bus.sel_valid && bus.sel_count != '0) begin
                    code_n  = bus.sel_code;
                    count_n = bus.sel_count;
                    state_n = ST_QUERY;
                end else begin
                    coin_en_c = 1'b1;
                end
            end
            ST_QUERY: begin
                if (bus.rsp_possible) begin
                    rem_n      = bus.rsp_remaining;
                    left_n     = count_q - COUNT_W'(1);
                    dispense_n = 1'b1;
                    dcode_n    = code_q;
                    state_n    = ST_DISPENSE;
                end else begin
                    deny_n       = 1'b1;
                    chg_valid_n  = (credit != '0);
                    chg_amount_n = credit;
                    state_n      = ST_CHANGE;
                end
            end
            ST_DISPENSE: begin
                // left_q counts pulses still owed after the one now on the output.
                if (left_q == '0) begin
                    chg_valid_n  = (rem_q != '0);
                    chg_amount_n = rem_q;
                    state_n      = ST_CHANGE;
                end else begin
                    left_n     = left_q - COUNT_W'(1);
                    dispense_n = 1'b1;
                    dcode_n    = code_q;
                end
            end
            ST_CHANGE: begin
                clear_c = 1'b1;
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        busy_n = (state_n == ST_QUERY) || (state_n == ST_DISPENSE) ||
                 (state_n == ST_CHANGE);
    end

    // Pricer request is a live decode so the response can be sampled in QUERY.
    assign bus.req_code  = (state_q == ST_QUERY) ? code_q  : '0;
    assign bus.req_count = (state_q == ST_QUERY) ? count_q : '0;
    assign bus.req_money = (state_q == ST_QUERY) ? credit  : '0;

    assign bus.dispense      = dispense_q;
    assign bus.dispense_code = dcode_q;
    assign bus.deny          = deny_q;
    assign bus.change_valid  = chg_valid_q;
    assign bus.change_amount = chg_amount_q;
    assign bus.credit        = credit;
    assign bus.busy          = busy_q;

endmodule

// File: tb/tb_vend_order_sequencer.sv
// Self-checking bench for vend_order_sequencer: directed scenarios followed by
// randomized coin/selection/cancel traffic against a transaction-level model.
module tb_vend_order_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    vend_order_sequencer_if bus ();

    vend_order_sequencer #(.TIMEOUT_CYC(20)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: credit held and whether a credit session is open.
    int m_credit = 0;
    bit m_active = 1'b0;

    task automatic check(input string tag, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.coin_valid    = 1'b0;
        bus.coin_value    = '0;
        bus.sel_valid     = 1'b0;
        bus.sel_code      = '0;
        bus.sel_count     = '0;
        bus.cancel        = 1'b0;
        bus.rsp_possible  = 1'b0;
        bus.rsp_remaining = '0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_reject"},  32'(bus.coin_reject),   0);
        check({tag, "_req"},     32'({bus.req_code, bus.req_count, bus.req_money}), 0);
        check({tag, "_disp"},    32'(bus.dispense),      0);
        check({tag, "_dcode"},   32'(bus.dispense_code), 0);
        check({tag, "_deny"},    32'(bus.deny),          0);
        check({tag, "_chg"},     32'(bus.change_valid),  0);
        check({tag, "_chg_amt"}, 32'(bus.change_amount), 0);
        check({tag, "_credit"},  32'(bus.credit),        0);
        check({tag, "_busy"},    32'(bus.busy),          0);
    endtask

    task automatic do_coin(input int v);
        int exp_rej;
        bus.coin_valid = 1'b1;
        bus.coin_value = 4'(v);
        tick();
        bus.coin_valid = 1'b0;
        exp_rej = (m_credit + v > 15) ? 1 : 0;
        if (exp_rej == 0) m_credit += v;
        m_active = 1'b1;
        check("coin_reject", 32'(bus.coin_reject), 32'(exp_rej));
        check("coin_credit", 32'(bus.credit), 32'(m_credit));
        check("coin_busy",   32'(bus.busy), 0);
    endtask

    task automatic finish_order();
        check("change_busy", 32'(bus.busy), 1);
        tick();
        check("idle_busy",   32'(bus.busy), 0);
        check("idle_credit", 32'(bus.credit), 0);
        check("idle_chg",    32'(bus.change_valid), 0);
        check("idle_req",    32'(bus.req_money), 0);
        m_credit = 0;
        m_active = 1'b0;
    endtask

    task automatic do_select(input int code, input int cnt, input bit poss,
                             input int rem, input bit inj);
        bus.rsp_possible  = poss;
        bus.rsp_remaining = 4'(rem);
        bus.sel_valid     = 1'b1;
        bus.sel_code      = 2'(code);
        bus.sel_count     = 3'(cnt);
        tick();
        bus.sel_valid = 1'b0;
        if (!m_active || cnt == 0) begin
            check("sel_ignored_busy",   32'(bus.busy), 0);
            check("sel_ignored_credit", 32'(bus.credit), 32'(m_credit));
            return;
        end
        check("query_busy",  32'(bus.busy), 1);
        check("query_code",  32'(bus.req_code), 32'(code));
        check("query_count", 32'(bus.req_count), 32'(cnt));
        check("query_money", 32'(bus.req_money), 32'(m_credit));
        tick();
        if (poss) begin
            for (int i = 0; i < cnt; i++) begin
                check("disp_pulse", 32'(bus.dispense), 1);
                check("disp_code",  32'(bus.dispense_code), 32'(code));
                check("disp_deny",  32'(bus.deny), 0);
                check("disp_chg",   32'(bus.change_valid), 0);
                if (inj && i == 0) begin
                    bus.coin_valid = 1'b1;
                    bus.coin_value = 4'(1);
                end
                tick();
                if (inj && i == 0) begin
                    bus.coin_valid = 1'b0;
                    check("busy_coin_reject", 32'(bus.coin_reject), 1);
                end
            end
            check("post_disp", 32'(bus.dispense), 0);
            check("chg_valid", 32'(bus.change_valid), (rem != 0) ? 1 : 0);
            if (rem != 0) check("chg_amount", 32'(bus.change_amount), 32'(rem));
        end else begin
            check("deny_pulse", 32'(bus.deny), 1);
            check("deny_disp",  32'(bus.dispense), 0);
            check("deny_chg",   32'(bus.change_valid), (m_credit != 0) ? 1 : 0);
            if (m_credit != 0) check("deny_amount", 32'(bus.change_amount), 32'(m_credit));
        end
        finish_order();
    endtask

    task automatic do_cancel(input bit with_sel, input bit with_coin);
        bus.cancel = 1'b1;
        if (with_sel) begin
            bus.sel_valid = 1'b1;
            bus.sel_count = 3'(1);
        end
        if (with_coin) begin
            bus.coin_valid = 1'b1;
            bus.coin_value = 4'(1);
        end
        tick();
        bus.cancel     = 1'b0;
        bus.sel_valid  = 1'b0;
        bus.coin_valid = 1'b0;
        if (!m_active) begin
            check("cancel_idle_busy", 32'(bus.busy), 0);
            check("cancel_idle_chg",  32'(bus.change_valid), 0);
            return;
        end
        check("cancel_chg",    32'(bus.change_valid), (m_credit != 0) ? 1 : 0);
        if (m_credit != 0) check("cancel_amount", 32'(bus.change_amount), 32'(m_credit));
        check("cancel_deny",   32'(bus.deny), 0);
        check("cancel_disp",   32'(bus.dispense), 0);
        check("cancel_reject", 32'(bus.coin_reject), 32'(with_coin));
        finish_order();
    endtask

    initial begin
        int waited;
        bit seen;
        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        check_zero("reset");
        rst_n = 1'b1;
        tick();

        // Fill to the limit, then overflow.
        do_coin(5); do_coin(5); do_coin(5); do_coin(1);
        do_select(1, 1, 1'b1, 3, 1'b0);
        // Pricer refusal.
        do_coin(5); do_coin(5);
        do_select(2, 3, 1'b0, 0, 1'b0);
        // Cancel wins over simultaneous selection and coin.
        do_coin(7);
        do_cancel(1'b1, 1'b1);
        // Multi-item order with exact payment; a coin during dispense bounces.
        do_coin(6); do_coin(6);
        do_select(3, 4, 1'b1, 0, 1'b1);
        // Zero-value coin opens a session without reject; zero count ignored.
        do_coin(0);
        do_select(0, 0, 1'b1, 0, 1'b0);
        do_cancel(1'b0, 1'b0);

        // Reset in the middle of dispensing.
        do_coin(5);
        bus.rsp_possible  = 1'b1;
        bus.rsp_remaining = 4'(2);
        bus.sel_valid     = 1'b1;
        bus.sel_code      = 2'(2);
        bus.sel_count     = 3'(4);
        tick();
        bus.sel_valid = 1'b0;
        tick();
        check("pre_rst_disp", 32'(bus.dispense), 1);
        rst_n = 1'b0;
        tick();
        check_zero("mid_rst");
        rst_n = 1'b1;
        m_credit = 0;
        m_active = 1'b0;
        tick();

        // Idle behaviour with credit parked in CREDIT.
        do_coin(6);
        seen   = 1'b0;
        waited = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            waited++;
            if (bus.change_valid) seen = 1'b1;
        end
`ifdef VEND_REFUND_TIMEOUT_EN
        check("timeout_seen",   32'(seen), 1);
        check("timeout_cycles", 32'(waited), 20);
        check("timeout_amount", 32'(bus.change_amount), 6);
        finish_order();
`else
        check("no_timeout",        32'(seen), 0);
        check("no_timeout_credit", 32'(bus.credit), 6);
        do_cancel(1'b0, 1'b0);
`endif

        // Randomized traffic.
        for (int it = 0; it < 200; it++) begin
            int op;
            op = int'($urandom_range(0, 9));
            if (op <= 4) begin
                if ($urandom_range(0, 3) == 0) do_coin(int'($urandom_range(0, 15)));
                else do_coin(int'($urandom_range(0, 6)));
            end else if (op <= 7) begin
                do_select(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                          1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                          1'($urandom_range(0, 1)));
            end else if (m_active) begin
                do_cancel(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end else begin
                do_cancel(1'b0, 1'b0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vend_order_sequencer.md
# vend_order_sequencer

Sequential order front-end that drives the combinational `vendingmachine` pricing core. It accumulates inserted coins into a credit register and latches a product selection. It then presents `code`/`count`/`money` to the pricer and samples `posibility`/`remaining`. Finally it issues dispense pulses and a single change/refund transaction back to the coin mechanism.

## Interface
Parameters:
- `CODE_W`, 2: product code width
- `COUNT_W`, 3: item count width
- `MONEY_W`, 4: credit/money width
- `TIMEOUT_CYC`, 1000: idle cycles before auto-refund (only with `VEND_REFUND_TIMEOUT_EN`)

Ports:
- `clk` input 1: single clock. All logic is on the rising edge.
- `rst_n` input 1: reset. Synchronous, active-low.
- `coin_valid` input 1: one-cycle coin strobe
- `coin_value` input MONEY_W: value of the strobed coin
- `coin_reject` output 1: one-cycle pulse; the coin was not credited
- `sel_valid` input 1: one-cycle selection strobe
- `sel_code` input CODE_W: requested product
- `sel_count` input COUNT_W: requested quantity
- `cancel` input 1: one-cycle refund request
- `req_code` output CODE_W: to pricer `code`
- `req_count` output COUNT_W: to pricer `count`
- `req_money` output MONEY_W: to pricer `money`
- `rsp_possible` input 1: from pricer `posibility`
- `rsp_remaining` input MONEY_W: from pricer `remaining`
- `dispense` output 1: one pulse per item
- `dispense_code` output CODE_W: product being dispensed, valid with `dispense`
- `deny` output 1: one-cycle pulse; the pricer refused the order
- `change_valid` output 1: one-cycle change strobe
- `change_amount` output MONEY_W: valid with `change_valid`
- `credit` output MONEY_W: current credit
- `busy` output 1: high in QUERY/DISPENSE/CHANGE

## Operation
- States: IDLE, CREDIT, QUERY, DISPENSE, CHANGE.
- **Reset:** every output is 0; state = IDLE; credit = 0.
- **Coins in IDLE/CREDIT:**
  - A coin sets `credit += coin_value` and moves to CREDIT.
  - If the sum would exceed 2^MONEY_W−1, credit is unchanged and `coin_reject` pulses.
  - `coin_value` = 0 is credited as a no-op, without a reject.
- **Coins in QUERY/DISPENSE/CHANGE:** always rejected.
- **Selection:** `sel_valid` in CREDIT with `sel_count` ≠ 0 latches code and count, then goes to QUERY.
  - `sel_count` = 0 is ignored.
  - `sel_valid` in IDLE is ignored.
- **QUERY (one cycle):**
  - `req_*` is driven from the latched selection and credit, and is held at 0 when not in QUERY.
  - The response is sampled at the end of the cycle.
  - possible = 1: latch `remaining`, go to DISPENSE.
  - possible = 0: pulse `deny`, latch change = credit, go to CHANGE.
- **DISPENSE:** emits exactly count `dispense` pulses on consecutive cycles, then goes to CHANGE.
- **CHANGE (one cycle):**
  - `change_valid` pulses only if the amount is ≠ 0.
  - Credit is cleared and the state returns to IDLE.
- **Cancel:** `cancel` in CREDIT latches change = credit and goes to CHANGE. It is ignored in all other states.
- **Simultaneous strobes in CREDIT:** priority is cancel > sel_valid > coin. The losing coin is rejected.
- **Mid-operation reset:** aborts immediately with no change issued. Credit is lost by design.

## Timing
- `sel_valid` at cycle N → QUERY in N+1 → `dispense` pulses in N+2 … N+1+count → `change_valid` in N+2+count → IDLE in N+3+count.
- Deny path: `deny` pulses in N+2 together with CHANGE. IDLE follows in N+3.
- A coin at cycle N is reflected on `credit` at N+1. `coin_reject` pulses in N+1.
- All outputs are registered except `req_*`, which is a decode of state and registers.

## Configuration
- `VEND_REFUND_TIMEOUT_EN` defined:
  - An idle counter runs in CREDIT and resets on any coin, selection or cancel.
  - Reaching TIMEOUT_CYC cycles behaves exactly like `cancel`.
- Undefined: no counter. CREDIT is held indefinitely.

## Structure
- Package `vend_pkg`:
  - State enum
  - CODE_W, COUNT_W and MONEY_W constants
  - Saturating-add limit constant
- Sub-module `vend_credit_acc`: credit register, overflow check and reject pulse.
- The FSM, dispense counter and optional timeout live in the top module.

## Test plan
- Coins 5, 5, 5 → credit 15. A fourth coin of 1 → `coin_reject`, credit stays 15.
- Credit 15, select code 1 / count 1, stub returns possible = 1 / remaining = 3 → one `dispense` with code 1, then `change_valid` with amount 3, then IDLE.
- Credit 10, select count 3, stub returns possible = 0 → `deny`, change 10, no `dispense`.
- Credit 7, `cancel` and `sel_valid` in the same cycle → refund of 7, no QUERY.
- Credit 12, select count 4, stub returns remaining = 0 → four consecutive `dispense` pulses, no `change_valid`. A coin strobed during DISPENSE → rejected.
- With `VEND_REFUND_TIMEOUT_EN` and TIMEOUT_CYC = 20: credit 6, no activity → refund of 6 after 20 cycles. `rst_n` asserted mid-DISPENSE → all outputs 0 on the next edge.
